// File: rtl/act_arb_pkg.sv
// ---------------------------------------------------------------------------
// act_arb_pkg
// Shared definitions for the activation global-buffer fetch arbiter:
//   - arb_state_e      : arbiter/sequencer state encoding (IDLE, BURST)
//   - ACT_ADDR_WIDTH   : default SRAM word address width
//   - ACT_DATA_WIDTH   : default SRAM word width
//   - ACT_LEN_WIDTH    : default burst length field width
// ---------------------------------------------------------------------------
package act_arb_pkg;

    localparam int ACT_ADDR_WIDTH = 12;
    localparam int ACT_DATA_WIDTH = 64;
    localparam int ACT_LEN_WIDTH  = 5;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_e;

    // Index width needed to address num_req requesters (at least one bit).
    function automatic int idx_width(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/act_fetch_arb_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. Searches req upward starting at ptr+1
// (wrapping modulo NUM_REQ) and returns the first set bit.
// Ports:
//   req     in  NUM_REQ  request vector
//   ptr     in  IDX_W    index of the most recently served requester
//   win_oh  out NUM_REQ  one-hot winner (all zero when req is zero)
//   win_idx out IDX_W    binary index of the winner (0 when req is zero)
// ---------------------------------------------------------------------------
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] win_oh,
    output logic [IDX_W-1:0]   win_idx
);

    logic [IDX_W:0] pos_s;
    logic           found_s;

    // First requester at or after ptr+1 in circular order wins.
    always_comb begin
        win_oh  = '0;
        win_idx = '0;
        found_s = 1'b0;
        pos_s   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos_s = {1'b0, ptr} + (IDX_W+1)'(k) + (IDX_W+1)'(1);
            if (pos_s >= (IDX_W+1)'(NUM_REQ)) begin
                pos_s = pos_s - (IDX_W+1)'(NUM_REQ);
            end else begin
                pos_s = pos_s;
            end
            if (!found_s && req[pos_s[IDX_W-1:0]]) begin
                found_s                  = 1'b1;
                win_idx                  = pos_s[IDX_W-1:0];
                win_oh[pos_s[IDX_W-1:0]] = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/act_fetch_arb.sv
// ---------------------------------------------------------------------------
// act_fetch_arb
// Round-robin arbiter and burst sequencer sharing the activation global
// buffer read port between NUM_REQ PE-cluster fetchers. The winner owns the
// port for one burst of cfg_len+1 consecutive words; read data (1-cycle SRAM
// latency) is routed back to the owner.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   cfg_len           burst length minus one, sampled at grant
//   req / req_addr    per-requester request level and start address
//   req_hold          per-requester back-pressure (owner's bit stalls issue)
//   gnt               one-hot owner, high for the whole burst
//   sram_rd_en/addr   SRAM read strobe and address
//   sram_rd_data      SRAM read data, valid one cycle after sram_rd_en
//   rsp_vld/data/last response to the owner, one cycle after each issue
//   busy              high while a burst is in progress
// Optional build macro ACT_FETCH_ARB_STAT_EN adds stat_clr, stat_busy_cyc
// and stat_hold_cyc (saturating utilisation counters, clear wins).
// ---------------------------------------------------------------------------
module act_fetch_arb
    import act_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = ACT_ADDR_WIDTH,
    parameter int DATA_WIDTH = ACT_DATA_WIDTH,
    parameter int LEN_WIDTH  = ACT_LEN_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [LEN_WIDTH-1:0]          cfg_len,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ-1:0]            req_hold,
    output logic [NUM_REQ-1:0]            gnt,
    output logic                          sram_rd_en,
    output logic [ADDR_WIDTH-1:0]         sram_rd_addr,
    input  logic [DATA_WIDTH-1:0]         sram_rd_data,
    output logic [NUM_REQ-1:0]            rsp_vld,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic                          rsp_last,
    output logic                          busy
`ifdef ACT_FETCH_ARB_STAT_EN
    ,
    input  logic                          stat_clr,
    output logic [31:0]                   stat_busy_cyc,
    output logic [31:0]                   stat_hold_cyc
`endif
);

    localparam int IDX_W = idx_width(NUM_REQ);

    arb_state_e             state_r;
    arb_state_e             next_state_s;
    logic [IDX_W-1:0]       ptr_r;
    logic [IDX_W-1:0]       owner_r;
    logic [ADDR_WIDTH-1:0]  base_r;
    logic [LEN_WIDTH-1:0]   len_r;
    logic [LEN_WIDTH-1:0]   cnt_r;
    logic [NUM_REQ-1:0]     gnt_r;
    logic [NUM_REQ-1:0]     rsp_vld_r;
    logic                   rsp_last_r;

    logic [NUM_REQ-1:0]     pick_oh_s;
    logic [IDX_W-1:0]       pick_idx_s;
    logic [ADDR_WIDTH-1:0]  pick_addr_s;
    logic                   grant_s;
    logic                   issue_s;
    logic                   last_s;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req     (req),
        .ptr     (ptr_r),
        .win_oh  (pick_oh_s),
        .win_idx (pick_idx_s)
    );

    // Start address of the arbitration winner.
    always_comb begin
        pick_addr_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_oh_s[i]) begin
                pick_addr_s = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            end else begin
                pick_addr_s = pick_addr_s;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode: arbitrate in IDLE, issue one word per unheld cycle in BURST.
    always_comb begin
        next_state_s = state_r;
        grant_s      = 1'b0;
        issue_s      = 1'b0;
        last_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (|req) begin
                    grant_s      = 1'b1;
                    next_state_s = ST_BURST;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_BURST: begin
                if (!req_hold[owner_r]) begin
                    issue_s = 1'b1;
                    if (cnt_r == len_r) begin
                        last_s       = 1'b1;
                        next_state_s = ST_IDLE;
                    end else begin
                        next_state_s = ST_BURST;
                    end
                end else begin
                    next_state_s = ST_BURST;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Burst context: owner, base, length, word counter, grant and rr pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r   <= IDX_W'(NUM_REQ - 1);
            owner_r <= '0;
            base_r  <= '0;
            len_r   <= '0;
            cnt_r   <= '0;
            gnt_r   <= '0;
        end else if (grant_s) begin
            owner_r <= pick_idx_s;
            base_r  <= pick_addr_s;
            len_r   <= cfg_len;
            cnt_r   <= '0;
            gnt_r   <= pick_oh_s;
        end else if (last_s) begin
            ptr_r   <= owner_r;
            cnt_r   <= '0;
            gnt_r   <= '0;
        end else if (issue_s) begin
            cnt_r   <= cnt_r + LEN_WIDTH'(1);
        end else begin
            cnt_r   <= cnt_r;
        end
    end

    // Response tags trail the issue by the SRAM's one-cycle latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_vld_r  <= '0;
            rsp_last_r <= 1'b0;
        end else begin
            rsp_vld_r  <= issue_s ? gnt_r : '0;
            rsp_last_r <= last_s;
        end
    end

    // Read strobe follows the owner's hold in the same cycle; address parks at 0.
    always_comb begin
        sram_rd_en = issue_s;
        if (issue_s) begin
            sram_rd_addr = base_r + ADDR_WIDTH'(cnt_r);
        end else begin
            sram_rd_addr = '0;
        end
    end

    assign gnt      = gnt_r;
    assign busy     = (state_r == ST_BURST);
    assign rsp_vld  = rsp_vld_r;
    assign rsp_last = rsp_last_r;
    assign rsp_data = sram_rd_data;

`ifdef ACT_FETCH_ARB_STAT_EN
    logic [31:0] busy_cyc_r;
    logic [31:0] hold_cyc_r;

    // Saturating utilisation counters; a clear request overrides counting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_cyc_r <= 32'd0;
            hold_cyc_r <= 32'd0;
        end else if (stat_clr) begin
            busy_cyc_r <= 32'd0;
            hold_cyc_r <= 32'd0;
        end else begin
            if ((state_r == ST_BURST) && (busy_cyc_r != 32'hFFFF_FFFF)) begin
                busy_cyc_r <= busy_cyc_r + 32'd1;
            end else begin
                busy_cyc_r <= busy_cyc_r;
            end
            if ((state_r == ST_BURST) && req_hold[owner_r] && (hold_cyc_r != 32'hFFFF_FFFF)) begin
                hold_cyc_r <= hold_cyc_r + 32'd1;
            end else begin
                hold_cyc_r <= hold_cyc_r;
            end
        end
    end

    assign stat_busy_cyc = busy_cyc_r;
    assign stat_hold_cyc = hold_cyc_r;
`endif

endmodule

// File: tb/tb_act_fetch_arb.sv
// ---------------------------------------------------------------------------
// tb_act_fetch_arb
// Directed scenarios plus randomized traffic for act_fetch_arb, compared
// cycle by cycle against a transaction-level reference model (owner, words
// done, pending response) kept in plain integers.
// ---------------------------------------------------------------------------
module tb_act_fetch_arb;

    localparam int N  = 4;
    localparam int AW = 12;
    localparam int DW = 64;
    localparam int LW = 5;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [LW-1:0]   cfg_len;
    logic [N-1:0]    req;
    logic [N*AW-1:0] req_addr;
    logic [N-1:0]    req_hold;
    logic [N-1:0]    gnt;
    logic            sram_rd_en;
    logic [AW-1:0]   sram_rd_addr;
    logic [DW-1:0]   sram_rd_data;
    logic [N-1:0]    rsp_vld;
    logic [DW-1:0]   rsp_data;
    logic            rsp_last;
    logic            busy;
`ifdef ACT_FETCH_ARB_STAT_EN
    logic            stat_clr;
    logic [31:0]     stat_busy_cyc;
    logic [31:0]     stat_hold_cyc;
`endif

    act_fetch_arb #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_len      (cfg_len),
        .req          (req),
        .req_addr     (req_addr),
        .req_hold     (req_hold),
        .gnt          (gnt),
        .sram_rd_en   (sram_rd_en),
        .sram_rd_addr (sram_rd_addr),
        .sram_rd_data (sram_rd_data),
        .rsp_vld      (rsp_vld),
        .rsp_data     (rsp_data),
        .rsp_last     (rsp_last),
        .busy         (busy)
`ifdef ACT_FETCH_ARB_STAT_EN
        ,
        .stat_clr      (stat_clr),
        .stat_busy_cyc (stat_busy_cyc),
        .stat_hold_cyc (stat_hold_cyc)
`endif
    );

    always #5 clk = ~clk;

    // SRAM contents as a pure function of address.
    function automatic logic [63:0] mem_word(input logic [11:0] a);
        return {4'hA, a, 4'h5, ~a, 32'(a) * 32'h9E37_79B9};
    endfunction

    // SRAM macro model: one-cycle read latency.
    always @(posedge clk) begin
        sram_rd_data <= sram_rd_en ? mem_word(sram_rd_addr) : 64'h0;
    end

    int total;
    int bad;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model state
    bit m_busy;
    int m_owner, m_base, m_len, m_done, m_ptr;
    bit m_pend, m_plast;
    int m_pown, m_paddr;

    // Per-test history, indexed by cycle number from the start of the test
    int          cyc_idx;
    logic [3:0]  h_gnt  [64];
    logic        h_en   [64];
    logic [11:0] h_addr [64];
    logic [3:0]  h_vld  [64];
    logic        h_last [64];
    logic        h_busy [64];

    task automatic model_reset();
        m_busy = 1'b0; m_owner = 0; m_base = 0; m_len = 0; m_done = 0;
        m_ptr = N - 1; m_pend = 1'b0; m_plast = 1'b0; m_pown = 0; m_paddr = 0;
    endtask

    // One clock cycle: compare at the falling edge, advance the model at the rising edge.
    task automatic cycle();
        bit          iss;
        logic [3:0]  e_gnt, e_vld;
        logic [11:0] e_addr;
        bit          found;
        @(negedge clk);
        iss    = m_busy && !req_hold[m_owner];
        e_gnt  = m_busy ? 4'(1 << m_owner) : 4'h0;
        e_addr = iss ? 12'((m_base + m_done) % 4096) : 12'h0;
        e_vld  = m_pend ? 4'(1 << m_pown) : 4'h0;
        check_eq("gnt",      64'(gnt),          64'(e_gnt));
        check_eq("busy",     64'(busy),         64'(m_busy));
        check_eq("rd_en",    64'(sram_rd_en),   64'(iss));
        check_eq("rd_addr",  64'(sram_rd_addr), 64'(e_addr));
        check_eq("rsp_vld",  64'(rsp_vld),      64'(e_vld));
        check_eq("rsp_last", 64'(rsp_last),     64'(m_pend && m_plast));
        if (m_pend) check_eq("rsp_data", rsp_data, mem_word(12'(m_paddr)));
        if (cyc_idx < 64) begin
            h_gnt[cyc_idx] = gnt; h_en[cyc_idx] = sram_rd_en; h_addr[cyc_idx] = sram_rd_addr;
            h_vld[cyc_idx] = rsp_vld; h_last[cyc_idx] = rsp_last; h_busy[cyc_idx] = busy;
        end
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            m_pend  = iss;
            m_pown  = m_owner;
            m_plast = iss && (m_done == m_len);
            m_paddr = int'(e_addr);
            if (m_busy) begin
                if (iss) begin
                    m_done++;
                    if (m_done > m_len) begin
                        m_busy = 1'b0;
                        m_ptr  = m_owner;
                    end
                end
            end else if (req != 0) begin
                found = 1'b0;
                for (int k = 1; k <= N; k++) begin
                    int j;
                    j = (m_ptr + k) % N;
                    if (!found && req[j]) begin
                        found   = 1'b1;
                        m_busy  = 1'b1;
                        m_owner = j;
                        m_base  = int'(req_addr[j*AW +: AW]);
                        m_len   = int'(cfg_len);
                        m_done  = 0;
                    end
                end
            end
        end
        #1;
        cyc_idx++;
    endtask

    task automatic idle(input int n);
        req = '0; req_hold = '0;
        repeat (n) cycle();
    endtask

    initial begin
        logic [11:0] wrap_exp [4];
        total = 0; bad = 0; cyc_idx = 0;
        rst_n = 1'b0; cfg_len = '0; req = '0; req_addr = '0; req_hold = '0;
`ifdef ACT_FETCH_ARB_STAT_EN
        stat_clr = 1'b0;
`endif
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_gnt",     64'(gnt), 64'h0);
        check_eq("rst_busy",    64'(busy), 64'h0);
        check_eq("rst_rd_en",   64'(sram_rd_en), 64'h0);
        check_eq("rst_rd_addr", 64'(sram_rd_addr), 64'h0);
        check_eq("rst_rsp_vld", 64'(rsp_vld), 64'h0);
        check_eq("rst_rsp_last",64'(rsp_last), 64'h0);
        cycle();
        rst_n = 1'b1;
        idle(2);

        // All four requesting, single-word bursts: order 0,1,2,3,0
        cyc_idx = 0; req = 4'hF; cfg_len = 5'd0;
        req_addr = {12'h300, 12'h200, 12'h100, 12'h000};
        repeat (9) cycle();
        idle(3);
        check_eq("rr_c1", 64'(h_gnt[1]), 64'h1);
        check_eq("rr_c2", 64'(h_gnt[2]), 64'h0);
        check_eq("rr_c3", 64'(h_gnt[3]), 64'h2);
        check_eq("rr_c5", 64'(h_gnt[5]), 64'h4);
        check_eq("rr_c7", 64'(h_gnt[7]), 64'h8);
        check_eq("rr_c9", 64'(h_gnt[9]), 64'h1);

        // Single requester 2, addr 0x010, four words
        cyc_idx = 0; req = 4'b0100; cfg_len = 5'd3;
        req_addr = {12'h0, 12'h010, 12'h0, 12'h0};
        cycle();
        idle(7);
        for (int c = 1; c <= 4; c++) begin
            check_eq("single_gnt",  64'(h_gnt[c]),  64'h4);
            check_eq("single_addr", 64'(h_addr[c]), 64'(12'h010 + 12'(c - 1)));
            check_eq("single_vld",  64'(h_vld[c+1]), 64'h4);
        end
        check_eq("single_last4", 64'(h_last[4]), 64'h0);
        check_eq("single_last5", 64'(h_last[5]), 64'h1);
        check_eq("single_idle5", 64'(h_busy[5]), 64'h0);
        check_eq("single_gnt5",  64'(h_gnt[5]),  64'h0);

        // Address wrap through the top of the buffer
        cyc_idx = 0; req = 4'b0001; cfg_len = 5'd3;
        req_addr = {12'h0, 12'h0, 12'h0, 12'hFFE};
        cycle();
        idle(7);
        wrap_exp[0] = 12'hFFE; wrap_exp[1] = 12'hFFF; wrap_exp[2] = 12'h000; wrap_exp[3] = 12'h001;
        for (int c = 0; c < 4; c++) check_eq("wrap_addr", 64'(h_addr[c+1]), 64'(wrap_exp[c]));

        // Hold on owner 1 in cycles 2-3
        cyc_idx = 0; req = 4'b0010; cfg_len = 5'd2;
        req_addr = {12'h0, 12'h0, 12'h100, 12'h0};
        for (int c = 0; c < 9; c++) begin
            req_hold = (c == 2 || c == 3) ? 4'b0010 : 4'b0000;
            if (c > 0) req = 4'b0000;
            cycle();
        end
        check_eq("hold_en1", 64'(h_en[1]), 64'h1);
        check_eq("hold_en2", 64'(h_en[2]), 64'h0);
        check_eq("hold_en3", 64'(h_en[3]), 64'h0);
        check_eq("hold_en4", 64'(h_en[4]), 64'h1);
        check_eq("hold_en5", 64'(h_en[5]), 64'h1);
        check_eq("hold_last5", 64'(h_last[5]), 64'h0);
        check_eq("hold_last6", 64'(h_last[6]), 64'h1);

        // Reset in the middle of an 8-word burst
        cyc_idx = 0; req = 4'b1000; cfg_len = 5'd7;
        req_addr = {12'h200, 12'h0, 12'h0, 12'h040};
        cycle();
        req = '0;
        repeat (3) cycle();
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_gnt",     64'(gnt), 64'h0);
        check_eq("mid_rst_busy",    64'(busy), 64'h0);
        check_eq("mid_rst_rd_en",   64'(sram_rd_en), 64'h0);
        check_eq("mid_rst_rd_addr", 64'(sram_rd_addr), 64'h0);
        check_eq("mid_rst_rsp_vld", 64'(rsp_vld), 64'h0);
        check_eq("mid_rst_last",    64'(rsp_last), 64'h0);
        model_reset();
        repeat (2) cycle();
        rst_n = 1'b1;
        cyc_idx = 0; req = 4'b1001; cfg_len = 5'd1;
        cycle();
        req = 4'b1000;
        repeat (4) cycle();
        idle(4);
        check_eq("post_rst_first", 64'(h_gnt[1]), 64'h1);
        check_eq("post_rst_next",  64'(h_gnt[4]), 64'h8);

`ifdef ACT_FETCH_ARB_STAT_EN
        stat_clr = 1'b1;
        cycle();
        stat_clr = 1'b0;
        cyc_idx = 0; req = 4'b0001; cfg_len = 5'd3;
        req_addr = {12'h0, 12'h0, 12'h0, 12'h080};
        for (int c = 0; c < 10; c++) begin
            req_hold = (c == 2 || c == 3) ? 4'b0001 : 4'b0000;
            if (c > 0) req = 4'b0000;
            cycle();
        end
        check_eq("stat_busy", 64'(stat_busy_cyc), 64'd6);
        check_eq("stat_hold", 64'(stat_hold_cyc), 64'd2);
        stat_clr = 1'b1;
        cycle();
        stat_clr = 1'b0;
        check_eq("stat_busy_clr", 64'(stat_busy_cyc), 64'd0);
        check_eq("stat_hold_clr", 64'(stat_hold_cyc), 64'd0);
`endif

        // Randomized traffic: requests, holds, lengths and addresses change every cycle
        for (int c = 0; c < 2000; c++) begin
            req = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            for (int i = 0; i < N; i++) begin
                req_hold[i] = ($urandom_range(0, 3) == 0);
                req_addr[i*AW +: AW] = ($urandom_range(0, 7) == 0) ?
                    12'(12'hFF0 + 12'($urandom_range(0, 15))) : 12'($urandom);
            end
            cfg_len = ($urandom_range(0, 15) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
            cycle();
        end
        idle(40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/act_fetch_arb.md
# act_fetch_arb

Round-robin arbiter and burst sequencer that shares the single read port of the activation global buffer between up to `NUM_REQ` PE-cluster activation fetchers. A requester wins the port for one row burst of `cfg_len+1` consecutive words. The block issues the SRAM reads for that burst and routes the 1-cycle-latency read data back to the owning requester. It sits between the per-PEC activation controllers (which raise fetch requests per row) and the activation SRAM macro.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters (2..8).
- `ADDR_WIDTH`, 12: SRAM word address width.
- `DATA_WIDTH`, 64: SRAM word width.
- `LEN_WIDTH`, 5: burst length field width.

Ports (clock and reset first):
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cfg_len`  in  LEN_WIDTH  burst length; the real value is `cfg_len+1`; sampled at grant.
- `req`  in  NUM_REQ  per-requester fetch request, level.
- `req_addr`  in  NUM_REQ*ADDR_WIDTH  per-requester start address; slice i belongs to requester i.
- `req_hold`  in  NUM_REQ  owner back-pressure; when high, no read is issued that cycle.
- `gnt`  out  NUM_REQ  one-hot; high for the whole burst of the owner.
- `sram_rd_en`  out  1  SRAM read strobe.
- `sram_rd_addr`  out  ADDR_WIDTH  SRAM read address.
- `sram_rd_data`  in  DATA_WIDTH  read data, valid 1 cycle after `sram_rd_en`.
- `rsp_vld`  out  NUM_REQ  one-hot data valid to the owner.
- `rsp_data`  out  DATA_WIDTH  data; a direct pass-through of `sram_rd_data`.
- `rsp_last`  out  1  marks the final word of a burst; qualified by `rsp_vld`.
- `busy`  out  1  high while the block is in BURST.

## Operation
State machine:
- IDLE → BURST when `|req`:
  - winner = first set `req` bit searching upward from `ptr+1` (mod NUM_REQ);
  - register `owner`, `base = req_addr[owner]`, `len = cfg_len`, `cnt = 0`.
- BURST issue condition: `~req_hold[owner]` → `sram_rd_en=1`, `sram_rd_addr = base+cnt`, `cnt++`.
- BURST → IDLE on the issue where `cnt==len`; at that point `ptr <= owner`.
- While `req_hold[owner]` is high, nothing is issued and `cnt` holds.

Rules:
- `req` is sampled only in IDLE. Dropping `req` mid-burst does not abort; the burst always completes.
- `gnt` is registered: it is high from the cycle after arbitration through the cycle of the last issue.
- Address arithmetic is modulo 2^ADDR_WIDTH. A burst crossing the top address wraps to 0.
- Response path: `rsp_vld[owner_d]`, `rsp_last` and `rsp_data` are valid one cycle after each issue. `owner_d` and `last_d` are delayed copies, so the response to the final word arrives in the cycle after `gnt` drops.
- Simultaneous requests: round-robin guarantees that each requester waits at most NUM_REQ−1 bursts.
- Reset values:
  - state=IDLE, `ptr=NUM_REQ-1` (requester 0 wins first);
  - `gnt=0`, `sram_rd_en=0`, `sram_rd_addr=0`, `rsp_vld=0`, `rsp_last=0`, `busy=0`, `cnt=0`.
  - Reset mid-burst discards the burst; the in-flight response is suppressed.

## Timing
- Cycle 0: IDLE with `req` high.
- Cycle 1: `gnt` high and the first read issues.
- Cycle 2: first `rsp_vld`.
- With no hold, a burst occupies cycles 1..L+1, where L=`cfg_len`.
- Cycle L+2: IDLE re-arbitrates. Cycle L+3: the next `gnt`. There is exactly one bubble cycle between bursts.
- Each hold cycle delays all subsequent issues by one.
- Maximum throughput is (L+1)/(L+2) words per cycle.

## Configuration
`ACT_FETCH_ARB_STAT_EN`:
- When defined, adds input `stat_clr` and outputs `stat_busy_cyc[31:0]` and `stat_hold_cyc[31:0]`:
  - `stat_busy_cyc` counts cycles in BURST;
  - `stat_hold_cyc` counts BURST cycles with owner hold high;
  - both are saturating, reset to 0, and synchronously cleared by `stat_clr` (clear wins over increment).
- When undefined, these ports and registers do not exist; all other behaviour is identical.

## Structure
- Shared package `act_arb_pkg`: state enum (IDLE, BURST) and the default width constants `ACT_ADDR_WIDTH`, `ACT_DATA_WIDTH`, `ACT_LEN_WIDTH`.
- One sub-module, `rr_pick`: combinational round-robin picker. Inputs: `req`, `ptr`. Outputs: one-hot winner and its index.

## Test plan
- Single requester: req[2]=1, addr=0x010, cfg_len=3 → `gnt[2]` cycles 1–4, reads 0x010..0x013, `rsp_vld[2]` cycles 2–5, `rsp_last` in cycle 5, idle in cycle 5.
- All four requesting after reset, cfg_len=0 → grant order 0,1,2,3,0, each `gnt` one cycle, spaced 2 cycles apart.
- Hold: owner 1, cfg_len=2, `req_hold[1]` high in cycles 2–3 → issues in cycles 1, 4, 5; `rsp_last` in cycle 6.
- Wrap: addr=0xFFE, cfg_len=3 → reads 0xFFE, 0xFFF, 0x000, 0x001.
- Reset asserted in the middle of an 8-word burst → all outputs 0 immediately. After release, req[3] and req[0] together → requester 0 granted first.
- With `ACT_FETCH_ARB_STAT_EN`: a 4-word burst with 2 hold cycles → busy=6, hold=2. Then `stat_clr` → both 0.
